apa102_frame_axis: RTL and testbench

//   AXI-Stream to APA102/Blinkt LED-chain frame driver. Accepts one 32-bit word per
//   LED on an AXIS slave and emits a complete frame on o_led_clk/o_led_data:

---
 rtl/apa102_pkg.sv | 22 ++
 rtl/apa102_frame_axis_if.sv | 14 +
 rtl/apa102_bit_serializer.sv | 69 ++++++
 rtl/apa102_frame_axis.sv | 133 +++++++++++++
 tb/tb_apa102_frame_axis.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apa102_pkg.sv
// apa102_pkg: shared state encoding and frame constants
// for the APA102 LED-chain frame driver.
package apa102_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        LOAD,
        END
    } state_t;

    localparam int          WORD_BITS  = 32;
    localparam logic [31:0] START_WORD = 32'h0;
    localparam logic [2:0]  HDR_BITS   = 3'b111;

    // LED word as it goes on the wire: top three bits always set.
    function automatic logic [31:0] led_word(input logic [28:0] payload);
        return {HDR_BITS, payload};
    endfunction

endpackage

// File: rtl/apa102_frame_axis_if.sv
// apa102_frame_axis_if: AXI-Stream word channel feeding
// the APA102 frame driver.
interface apa102_frame_axis_if;
    import apa102_pkg::*;

    logic [WORD_BITS-1:0] data;
    logic                 tvalid;
    logic                 tlast;
    logic                 tready;

    modport master (output data, tvalid, tlast, input tready);
    modport slave  (input data, tvalid, tlast, output tready);

endinterface

// File: rtl/apa102_bit_serializer.sv
// apa102_bit_serializer: shifts a word out MSB first as bit cells,
// clock low then high for CLK_DIV cycles each; done on the last cycle.
module apa102_bit_serializer #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4,
    parameter int CW      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic [CW-1:0]    nbits,
    input  logic             fill,
    output logic             led_clk,
    output logic             led_data,
    output logic             done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    left;
    logic [DW-1:0]    div;
    logic             phase;
    logic             fill_q;
    logic             run;

    assign led_clk  = run && phase;
    assign led_data = sh[WIDTH-1];
    assign done     = run && phase && (div == DIV_LAST)
                      && (left == CW'(1));

    // Cell timing and shift register; a load may land on the done cycle
    // so consecutive words run back to back.
    always_ff @(posedge clk) begin
        if (rst) begin
            run    <= 1'b0;
            sh     <= '0;
            left   <= '0;
            div    <= '0;
            phase  <= 1'b0;
            fill_q <= 1'b0;
        end else if (load) begin
            run    <= 1'b1;
            sh     <= word;
            left   <= nbits;
            div    <= '0;
            phase  <= 1'b0;
            fill_q <= fill;
        end else if (run) begin
            if (div == DIV_LAST) begin
                div   <= '0;
                phase <= !phase;
                if (phase) begin
                    if (left == CW'(1)) begin
                        run <= 1'b0;
                    end else begin
                        left <= left - CW'(1);
                        sh   <= {sh[WIDTH-2:0], fill_q};
                    end
                end
            end else begin
                div <= div + DW'(1);
            end
        end
    end

endmodule

// File: rtl/apa102_frame_axis.sv
// apa102_frame_axis: AXI-Stream LED words in, APA102 frame out
// (start frame, NUM_LEDS words, all-ones end frame).
module apa102_frame_axis
    import apa102_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int CLK_DIV  = 4,
    parameter int END_BITS = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    apa102_frame_axis_if.slave  s_axis,
    output logic                o_led_clk,
    output logic                o_led_data,
    output logic                o_busy,
    output logic                o_frame_done,
    output logic                o_len_err
);

    localparam int MAXB = (END_BITS > WORD_BITS) ? END_BITS : WORD_BITS;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int NW   = $clog2(NUM_LEDS + 1);
    localparam logic [NW-1:0] LAST_CNT = NW'(NUM_LEDS);

    state_t          state, state_n;
    logic [NW-1:0]   cnt, cnt_n, cnt_inc;
    logic [31:0]     word_q;
    logic            last_q;
    logic            xfer;
    logic            ser_load, ser_fill, ser_done;
    logic [31:0]     ser_word;
    logic [CW-1:0]   ser_bits;

    assign s_axis.tready = (state == IDLE || state == LOAD) && !i_reset;
    assign xfer    = s_axis.tvalid && s_axis.tready;
    assign o_busy  = (state != IDLE);
    assign cnt_inc = cnt + NW'(1);

    // State, LED counter and the word latched on each transfer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            word_q <= '0;
            last_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (xfer) begin
                word_q <= led_word(s_axis.data[28:0]);
                last_q <= s_axis.tlast;
            end
        end
    end

    // Next state, serializer loads and the status pulses.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        ser_load     = 1'b0;
        ser_word     = START_WORD;
        ser_bits     = CW'(WORD_BITS);
        ser_fill     = 1'b0;
        o_frame_done = 1'b0;
        o_len_err    = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    state_n  = START;
                    ser_load = 1'b1;
                end
            end
            START: begin
                if (ser_done) begin
                    state_n  = SHIFT;
                    ser_load = 1'b1;
                    ser_word = word_q;
                end
            end
            SHIFT: begin
                if (ser_done) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == LAST_CNT || last_q) begin
                        state_n   = END;
                        ser_load  = 1'b1;
                        ser_word  = '1;
                        ser_bits  = CW'(END_BITS);
                        ser_fill  = 1'b1;
                        o_len_err = (cnt_inc != LAST_CNT) || !last_q;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    state_n  = SHIFT;
                    ser_load = 1'b1;
                    ser_word = led_word(s_axis.data[28:0]);
                end
            end
            END: begin
                if (ser_done) begin
                    state_n      = IDLE;
                    cnt_n        = '0;
                    o_frame_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (i_reset) begin
            o_frame_done = 1'b0;
            o_len_err    = 1'b0;
        end
    end

    apa102_bit_serializer #(
        .WIDTH   (WORD_BITS),
        .CLK_DIV (CLK_DIV),
        .CW      (CW)
    ) u_ser (
        .clk      (i_clk),
        .rst      (i_reset),
        .load     (ser_load),
        .word     (ser_word),
        .nbits    (ser_bits),
        .fill     (ser_fill),
        .led_clk  (o_led_clk),
        .led_data (o_led_data),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_apa102_frame_axis.sv
// tb_apa102_frame_axis: scoreboard bench; the model queues expected
// wire words per accepted LED word, a monitor decodes the LED bus.
module tb_apa102_frame_axis;

    localparam int NLED = 2;
    localparam int CD   = 2;
    localparam int EB   = 32;
    localparam int MAXW = 5000;
    localparam int FT   = (32 + 32 * NLED + EB) * 2 * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led_clk, led_data, busy, frame_done, len_err;

    apa102_frame_axis_if axis();

    apa102_frame_axis #(
        .NUM_LEDS (NLED),
        .CLK_DIV  (CD),
        .END_BITS (EB)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .s_axis       (axis),
        .o_led_clk    (led_clk),
        .o_led_data   (led_data),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_len_err    (len_err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [31:0] exp_q[$];
    int m_cnt       = 0;
    int exp_len_err = 0;
    int exp_done    = 0;
    int act_len_err = 0;
    int act_done    = 0;
    int done_cyc    = 0;
    int rise_cyc    = 0;
    int last_acc    = 0;
    bit want_rise   = 0;

    // Cycle stamp for timing checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act,
                         input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one accepted LED word -> expected wire words.
    task automatic model_accept(input logic [31:0] d, input bit last);
        if (m_cnt == 0) begin
            check("accept_when_idle", busy, 0);
            exp_q.push_back(32'h0);
        end else begin
            check("accept_mid_frame", busy, 1);
        end
        exp_q.push_back({3'b111, d[28:0]});
        m_cnt++;
        if (last || m_cnt == NLED) begin
            if (!(last && m_cnt == NLED)) exp_len_err++;
            for (int i = 0; i < EB / 32; i++) exp_q.push_back(32'hFFFF_FFFF);
            exp_done++;
            m_cnt = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer.
    task automatic send(input logic [31:0] d, input bit last,
                        input int gap);
        int n;
        bit gap_ok;
        if (gap > 0) begin
            n = 0;
            @(negedge clk);
            while (!axis.tready && n < MAXW) begin
                @(negedge clk);
                n++;
            end
            check("ready_wait", n < MAXW, 1);
            gap_ok = 1;
            repeat (gap) begin
                if (led_clk !== 1'b0) gap_ok = 0;
                @(negedge clk);
            end
            check("gap_clk_low", gap_ok, 1);
            @(posedge clk);
            #1;
        end
        axis.data   = d;
        axis.tlast  = last;
        axis.tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!axis.tready && n < MAXW) begin
            @(negedge clk);
            n++;
        end
        if (n >= MAXW) begin
            check("send_timeout", 1, 0);
        end else begin
            model_accept(d, last);
        end
        @(posedge clk);
        #1;
        last_acc    = cyc;
        axis.tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || act_done != exp_done) && n < MAXW) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, n < MAXW, 1);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_len_err_cnt"}, act_len_err, exp_len_err);
        check({tag, "_done_cnt"}, act_done, exp_done);
        @(posedge clk);
        #1;
    endtask

    // LED bus monitor: bit capture on rising clock, level timing,
    // data stability while high, status pulse counting.
    logic        prev_clk  = 0;
    logic        prev_data = 0;
    logic        prev_done = 0;
    logic [31:0] acc       = '0;
    int          nbits     = 0;
    int          hi_run    = 0;
    int          lo_run    = 0;

    always @(negedge clk) begin
        if (rst) begin
            nbits    = 0;
            hi_run   = 0;
            lo_run   = 0;
            prev_clk = 0;
        end else begin
            if (led_clk && !prev_clk) begin
                check("clk_low_len", lo_run >= CD, 1);
                check("data_setup", led_data, prev_data);
                if (want_rise) begin
                    rise_cyc  = cyc;
                    want_rise = 0;
                end
                acc = {acc[30:0], led_data};
                nbits++;
                if (nbits == 32) begin
                    nbits = 0;
                    check("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("led_word", acc, exp_q.pop_front());
                end
                hi_run = 1;
            end else if (led_clk) begin
                check("data_stable_hi", led_data, prev_data);
                hi_run++;
            end else if (prev_clk) begin
                check("clk_high_len", hi_run, CD);
                lo_run = 1;
            end else begin
                lo_run++;
            end
            prev_clk  = led_clk;
            prev_data = led_data;
            if (frame_done) begin
                check("done_one_cycle", prev_done, 0);
                act_done++;
                done_cyc = cyc;
            end
            if (len_err) act_len_err++;
            prev_done = frame_done;
        end
    end

    initial begin
        int acc0;
        int len;
        bit last;
        axis.data   = '0;
        axis.tlast  = 1'b0;
        axis.tvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led_clk", led_clk, 0);
        check("rst_led_data", led_data, 0);
        check("rst_busy", busy, 0);
        check("rst_tready", axis.tready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_len_err", len_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed two-word frame with timing.
        want_rise = 1;
        send(32'h00FF_0000, 0, 0);
        acc0 = last_acc;
        send(32'hE100_0000, 1, 0);
        wait_idle("t1");
        check("t1_first_rise", rise_cyc - acc0, CD);
        check("t1_frame_time", done_cyc - acc0, FT);

        // Same frame with a 20-cycle valid gap in LOAD.
        send(32'h00FF_0000, 0, 0);
        acc0 = last_acc;
        send(32'hE100_0000, 1, 20);
        wait_idle("t2");
        check("t2_frame_time", done_cyc - acc0, FT + 21);

        // Short frame, then a word held waiting through the end frame.
        send($urandom, 1, 0);
        send($urandom, 0, 0);
        send($urandom, 1, 0);
        wait_idle("t3");

        // Missing tlast, then the next word opens a fresh frame.
        send($urandom, 0, 0);
        send($urandom, 0, 0);
        send($urandom, 0, 0);
        send($urandom, 1, 0);
        wait_idle("t4");

        // Reset in the middle of the first LED word.
        send($urandom, 0, 0);
        repeat (150) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_led_clk", led_clk, 0);
        check("t5_led_data", led_data, 0);
        check("t5_busy", busy, 0);
        check("t5_tready", axis.tready, 1);
        @(posedge clk);
        #1;
        send($urandom, 0, 0);
        send($urandom, 1, 0);
        wait_idle("t5");

        // Random frame lengths, tlast placement and gaps.
        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(1, 3);
            for (int w = 0; w < len; w++) begin
                last = (w == len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                send($urandom, last,
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0);
            end
            if (m_cnt != 0) send($urandom, 1, 0);
            wait_idle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
